cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter PREG_WIDTH, default 7, physical register tag width.
REQ-002 SHALL have parameter ROB_WIDTH, default 4, ROB tag width.
REQ-003 SHALL have parameter N_REQ, default 3, number of execution-unit requesters (0=ALU, 1=BRU, 2=LSU).
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, holding-queue entries per requester.
REQ-005 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port: i_req_valid  in  N_REQ  per-EU result valid.
REQ-008 SHALL have port: i_req_prd  in  N_REQ x PREG_WIDTH  per-EU destination physical register.
REQ-009 SHALL have port: i_req_rob_tag  in  N_REQ x ROB_WIDTH  per-EU ROB tag.
REQ-010 SHALL have port: i_req_data  in  N_REQ x 32  per-EU result value.
REQ-011 SHALL have port: o_req_ready  out  N_REQ  per-EU queue can accept.
REQ-012 SHALL have port: branch_mispredict  in  1  synchronous flush.
REQ-013 SHALL have port: o_cdb_valid  out  1  broadcast valid, feeds every RS i_cdb_valid.
REQ-014 SHALL have port: o_cdb_prd  out  PREG_WIDTH  broadcast tag.
REQ-015 SHALL have port: o_cdb_rob_tag  out  ROB_WIDTH  ROB entry to mark complete.
REQ-016 SHALL have port: o_cdb_data  out  32  broadcast result.
REQ-017 SHALL have port: o_cdb_src  out  2  index of granted requester.

Function
REQ-018 Each requester SHALL own a FIFO_DEPTH-entry FIFO of {prd, rob_tag, data}.
REQ-019 Enqueue SHALL occur at edge N when i_req_valid[k] && o_req_ready[k]; valid without ready SHALL be dropped (EU stalls).
REQ-020 o_req_ready[k] SHALL equal (count[k] < FIFO_DEPTH) from registered count only, with no same-cycle pop bypass.
REQ-021 An entry enqueued at edge N SHALL be eligible for grant in cycle N+1 (one-cycle minimum latency), never in cycle N.
REQ-022 Each cycle at most one non-empty FIFO SHALL be granted; CDB outputs SHALL be driven combinationally from the granted FIFO head, and that head popped at the next edge.
REQ-023 Arbitration SHALL be round-robin: priority order starts at rr_ptr; after granting k, rr_ptr SHALL become (k+1) mod N_REQ; with no grant, rr_ptr holds.
REQ-024 With no grant, o_cdb_valid SHALL be 0 and o_cdb_prd/rob_tag/data/src SHALL be 0.
REQ-025 Simultaneous push and pop on the same FIFO SHALL leave count unchanged and keep FIFO order.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH nor underflow.
REQ-027 prd==0 entries SHALL be broadcast unchanged; x0 filtering is the consumer's job.
REQ-028 In a branch_mispredict cycle: o_cdb_valid SHALL be 0, no pop, no enqueue, all FIFOs emptied at the edge, rr_ptr unchanged.
REQ-029 No grant SHALL be lost: every accepted entry SHALL be broadcast exactly once unless flushed.

Reset
REQ-030 On reset assertion, independent of clk, all counts/pointers SHALL clear, rr_ptr SHALL be 0, FIFO payload need not clear.
REQ-031 During and after reset: o_cdb_valid=0, all CDB payload outputs 0, o_req_ready all ones.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; none broadcast after release.

Structure
REQ-033 A shared package SHALL hold the cdb_entry_t struct {prd, rob_tag, data} and EU index constants ALU=0, BRU=1, LSU=2.
REQ-034 The per-requester queue SHALL be one sub-module, cdb_fifo, instantiated N_REQ times; arbiter and rr_ptr stay in cdb_arbiter.

Verification
REQ-035 Reset then idle -> o_cdb_valid=0, o_req_ready=3'b111, outputs 0.
REQ-036 ALU pushes prd=5, rob=3, data=0xDEAD at edge N -> cycle N+1 o_cdb_valid=1, prd=5, rob_tag=3, data=0xDEAD, src=0; cycle N+2 valid=0.
REQ-037 All three push at same edge, rr_ptr=0 -> broadcasts in order src 0,1,2 on three consecutive cycles; then a new BRU-only push -> src=1 next.
REQ-038 LSU pushes 2 entries while ALU keeps winning -> o_req_ready[2]=0 after second push; third LSU valid dropped; LSU granted within N_REQ cycles, ready returns to 1 cycle after pop.
REQ-039 Queue 2 ALU + 1 BRU entries, assert branch_mispredict one cycle -> that cycle o_cdb_valid=0; afterwards no broadcasts, ready=3'b111, rr_ptr unchanged.
REQ-040 Assert reset asynchronously mid-cycle with entries queued -> outputs 0 immediately, nothing broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: queued result entry and EU indices.
package cdb_arbiter_pkg;

    localparam int CDB_PREG_WIDTH = 7;
    localparam int CDB_ROB_WIDTH  = 4;
    localparam int CDB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        EU_ALU = 2'd0,
        EU_BRU = 2'd1,
        EU_LSU = 2'd2
    } eu_idx_e;

    typedef struct packed {
        logic [CDB_PREG_WIDTH-1:0] prd;
        logic [CDB_ROB_WIDTH-1:0]  rob_tag;
        logic [CDB_DATA_WIDTH-1:0] data;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-EU holding queue: entry visible at head the cycle after push, popped on pop_i.
// rdy_o comes from the registered count only; push when full or pop when empty is ignored.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       push_i,
    input  cdb_entry_t push_dat_i,
    input  logic       pop_i,
    output cdb_entry_t head_o,
    output logic       empty_o,
    output logic       rdy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign rdy_o   = (cnt_q < CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && rdy_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over per-EU queues; one-cycle minimum enqueue-to-broadcast latency.
// EUs see o_req_ready low while their queue is full; valid without ready is dropped.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int PREG_WIDTH = CDB_PREG_WIDTH,
    parameter int ROB_WIDTH  = CDB_ROB_WIDTH,
    parameter int N_REQ      = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_REQ-1:0]                    i_req_valid,
    input  logic [N_REQ-1:0][PREG_WIDTH-1:0]    i_req_prd,
    input  logic [N_REQ-1:0][ROB_WIDTH-1:0]     i_req_rob_tag,
    input  logic [N_REQ-1:0][31:0]              i_req_data,
    output logic [N_REQ-1:0]                    o_req_ready,
    input  logic                                branch_mispredict,
    output logic                                o_cdb_valid,
    output logic [PREG_WIDTH-1:0]               o_cdb_prd,
    output logic [ROB_WIDTH-1:0]                o_cdb_rob_tag,
    output logic [31:0]                         o_cdb_data,
    output logic [1:0]                          o_cdb_src
);

    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [RR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0] grant_idx;
    logic            grant_vld;
    logic [N_REQ-1:0] fifo_empty, fifo_push, fifo_pop;
    cdb_entry_t       fifo_head [N_REQ];
    cdb_entry_t       grant_ent;

    for (genvar k = 0; k < N_REQ; k++) begin : g_q
        cdb_entry_t push_dat;
        assign push_dat.prd     = CDB_PREG_WIDTH'(i_req_prd[k]);
        assign push_dat.rob_tag = CDB_ROB_WIDTH'(i_req_rob_tag[k]);
        assign push_dat.data    = i_req_data[k];
        assign fifo_push[k]     = i_req_valid[k] && o_req_ready[k] && !branch_mispredict;

        cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (branch_mispredict),
            .push_i     (fifo_push[k]),
            .push_dat_i (push_dat),
            .pop_i      (fifo_pop[k]),
            .head_o     (fifo_head[k]),
            .empty_o    (fifo_empty[k]),
            .rdy_o      (o_req_ready[k])
        );
    end

    // Scan starting at rr_ptr_q; the first non-empty queue wins. A flush cycle grants nothing.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        fifo_pop  = '0;
        rr_ptr_d  = rr_ptr_q;
        if (!branch_mispredict) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = (int'(rr_ptr_q) + i) % N_REQ;
                if (!grant_vld && !fifo_empty[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = RR_W'(idx);
                end
            end
        end
        if (grant_vld) begin
            fifo_pop[grant_idx] = 1'b1;
            rr_ptr_d = (grant_idx == RR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign grant_ent     = fifo_head[grant_idx];
    assign o_cdb_valid   = grant_vld;
    assign o_cdb_prd     = grant_vld ? PREG_WIDTH'(grant_ent.prd) : '0;
    assign o_cdb_rob_tag = grant_vld ? ROB_WIDTH'(grant_ent.rob_tag) : '0;
    assign o_cdb_data    = grant_vld ? grant_ent.data : '0;
    assign o_cdb_src     = grant_vld ? 2'(grant_idx) : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts queued at stimulus time, popped by a monitor.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       i_req_valid = '0;
    logic [2:0][6:0]  i_req_prd = '0;
    logic [2:0][3:0]  i_req_rob_tag = '0;
    logic [2:0][31:0] i_req_data = '0;
    logic [2:0]       o_req_ready;
    logic             branch_mispredict = 1'b0;
    logic             o_cdb_valid;
    logic [6:0]       o_cdb_prd;
    logic [3:0]       o_cdb_rob_tag;
    logic [31:0]      o_cdb_data;
    logic [1:0]       o_cdb_src;

    typedef struct packed {
        logic [6:0]  prd;
        logic [3:0]  rob;
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .i_req_valid       (i_req_valid),
        .i_req_prd         (i_req_prd),
        .i_req_rob_tag     (i_req_rob_tag),
        .i_req_data        (i_req_data),
        .o_req_ready       (o_req_ready),
        .branch_mispredict (branch_mispredict),
        .o_cdb_valid       (o_cdb_valid),
        .o_cdb_prd         (o_cdb_prd),
        .o_cdb_rob_tag     (o_cdb_rob_tag),
        .o_cdb_data        (o_cdb_data),
        .o_cdb_src         (o_cdb_src)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic [6:0] prd, input logic [3:0] rob, input logic [31:0] d);
        i_req_valid[k]   = 1'b1;
        i_req_prd[k]     = prd;
        i_req_rob_tag[k] = rob;
        i_req_data[k]    = d;
    endtask

    task automatic expect_bc(input logic [6:0] prd, input logic [3:0] rob, input logic [31:0] d, input logic [1:0] src);
        exp_t e;
        e.prd = prd; e.rob = rob; e.data = d; e.src = src;
        sb.push_back(e);
    endtask

    task automatic clr();
        i_req_valid = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got.prd = o_cdb_prd; got.rob = o_cdb_rob_tag; got.data = o_cdb_data; got.src = o_cdb_src;
        checks++;
        if (o_cdb_valid) begin
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_bcast got=%h exp=none t=%0t", got, $time);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL bcast got=%h exp=%h t=%0t", got, e, $time);
                end
            end
        end else if (got !== '0) begin
            failures++;
            $display("FAIL idle_payload got=%h exp=0 t=%0t", got, $time);
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(o_cdb_valid), 64'd0);
        chk("rst_ready", 64'(o_req_ready), 64'h7);
        chk("rst_prd", 64'(o_cdb_prd), 64'd0);
        chk("rst_data", 64'(o_cdb_data), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_valid", 64'(o_cdb_valid), 64'd0);
        chk("idle_ready", 64'(o_req_ready), 64'h7);

        // Single ALU result: visible one cycle after the enqueue edge, gone the cycle after
        tick();
        drive(EU_ALU, 7'd5, 4'd3, 32'hDEAD);
        expect_bc(7'd5, 4'd3, 32'hDEAD, EU_ALU);
        @(negedge clk);
        chk("no_bypass", 64'(o_cdb_valid), 64'd0);
        tick();
        clr();
        @(negedge clk);
        chk("lat_valid", 64'(o_cdb_valid), 64'd1);
        chk("lat_src", 64'(o_cdb_src), 64'd0);
        chk("lat_data", 64'(o_cdb_data), 64'hDEAD);
        @(negedge clk);
        chk("lat_n2_idle", 64'(o_cdb_valid), 64'd0);

        // All three at once from rr_ptr=0, then a lone BRU (prd 0 passes through)
        tick(); reset = 1'b1; tick(); tick(); reset = 1'b0;
        drive(EU_ALU, 7'd10, 4'd1, 32'h1111);
        drive(EU_BRU, 7'd11, 4'd2, 32'h2222);
        drive(EU_LSU, 7'd12, 4'd4, 32'h3333);
        expect_bc(7'd10, 4'd1, 32'h1111, EU_ALU);
        expect_bc(7'd11, 4'd2, 32'h2222, EU_BRU);
        expect_bc(7'd12, 4'd4, 32'h3333, EU_LSU);
        tick();
        clr();
        @(negedge clk); chk("rr_src0", 64'(o_cdb_src), 64'd0);
        @(negedge clk); chk("rr_src1", 64'(o_cdb_src), 64'd1);
        @(negedge clk); chk("rr_src2", 64'(o_cdb_src), 64'd2);
        tick();
        drive(EU_BRU, 7'd0, 4'd5, 32'h4444);
        expect_bc(7'd0, 4'd5, 32'h4444, EU_BRU);
        tick();
        clr();
        @(negedge clk); chk("bru_only_src", 64'(o_cdb_src), 64'd1);
        repeat (2) tick();

        // LSU fills its queue while ALU keeps pushing; third LSU valid is dropped
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        drive(EU_ALU, 7'h21, 4'd1, 32'hA0);
        drive(EU_LSU, 7'h31, 4'd2, 32'hB0);
        expect_bc(7'h21, 4'd1, 32'hA0, EU_ALU);
        expect_bc(7'h31, 4'd2, 32'hB0, EU_LSU);
        expect_bc(7'h22, 4'd3, 32'hA1, EU_ALU);
        expect_bc(7'h32, 4'd4, 32'hB1, EU_LSU);
        expect_bc(7'h23, 4'd5, 32'hA2, EU_ALU);
        tick();
        drive(EU_ALU, 7'h22, 4'd3, 32'hA1);
        drive(EU_LSU, 7'h32, 4'd4, 32'hB1);
        tick();
        chk("lsu_full", 64'(o_req_ready[2]), 64'd0);
        chk("ready_after_2", 64'(o_req_ready), 64'h3);
        drive(EU_ALU, 7'h23, 4'd5, 32'hA2);
        drive(EU_LSU, 7'h33, 4'd6, 32'hBF);
        tick();
        clr();
        chk("lsu_ready_back", 64'(o_req_ready[2]), 64'd1);
        chk("ready_after_3", 64'(o_req_ready), 64'h6);
        repeat (4) tick();

        // Flush with 2 ALU + 1 BRU queued (rr_ptr=1 here, so BRU drains once first)
        drive(EU_ALU, 7'h41, 4'd3, 32'hC0);
        drive(EU_BRU, 7'h42, 4'd4, 32'hC1);
        expect_bc(7'h42, 4'd4, 32'hC1, EU_BRU);
        tick();
        drive(EU_ALU, 7'h43, 4'd5, 32'hC2);
        drive(EU_BRU, 7'h44, 4'd6, 32'hC3);
        tick();
        clr();
        branch_mispredict = 1'b1;
        drive(EU_LSU, 7'h45, 4'd7, 32'hC4);
        @(negedge clk);
        chk("flush_valid", 64'(o_cdb_valid), 64'd0);
        tick();
        branch_mispredict = 1'b0;
        clr();
        chk("flush_ready", 64'(o_req_ready), 64'h7);
        @(negedge clk);
        chk("flush_quiet", 64'(o_cdb_valid), 64'd0);
        // rr_ptr must still be 2: ALU before BRU
        tick();
        drive(EU_ALU, 7'h46, 4'd8, 32'hD0);
        drive(EU_BRU, 7'h47, 4'd9, 32'hD1);
        expect_bc(7'h46, 4'd8, 32'hD0, EU_ALU);
        expect_bc(7'h47, 4'd9, 32'hD1, EU_BRU);
        tick();
        clr();
        repeat (3) tick();

        // Asynchronous reset mid-cycle with entries queued (rr_ptr=2: LSU goes first)
        drive(EU_ALU, 7'h51, 4'd10, 32'hE0);
        drive(EU_BRU, 7'h52, 4'd11, 32'hE1);
        drive(EU_LSU, 7'h53, 4'd12, 32'hE2);
        expect_bc(7'h53, 4'd12, 32'hE2, EU_LSU);
        tick();
        clr();
        tick();
        chk("pre_arst_valid", 64'(o_cdb_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(o_cdb_valid), 64'd0);
        chk("arst_prd", 64'(o_cdb_prd), 64'd0);
        chk("arst_data", 64'(o_cdb_data), 64'd0);
        chk("arst_src", 64'(o_cdb_src), 64'd0);
        chk("arst_ready", 64'(o_req_ready), 64'h7);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) tick();
        chk("post_arst_ready", 64'(o_req_ready), 64'h7);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
